// File: rtl/branch_target_predictor_pkg.sv
// Shared constants, opcode decode helpers for the branch target predictor.
package branch_target_predictor_pkg;

    // RV32 control-flow major opcodes (inst[6:0])
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // 2-bit direction counter encodings: weakly taken / weakly not-taken.
    // The top derives the same values generically for any counter width.
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_WNT = 2'b01;

    // True for any opcode that redirects control flow
    function automatic logic is_cf(input logic [6:0] opcode);
        return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
    endfunction

    // Unconditional jumps are always taken regardless of the resolved direction
    function automatic logic is_jump(input logic [6:0] opcode);
        return (opcode == OP_JAL) || (opcode == OP_JALR);
    endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch-lookup, execute-train and status bundle of the branch target predictor.
interface branch_target_predictor_if #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 32
);
    // fetch lookup
    logic [XLEN-1:0]   if_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;
    // execute training
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_inst;
    logic              ex_taken;
    logic [XLEN-1:0]   ex_target;
    logic              ex_pred_taken;
    logic [XLEN-1:0]   ex_pred_target;
    logic              inv_all;
    // redirect and performance
    logic              flush;
    logic [XLEN-1:0]   redirect_pc;
    logic [PERF_W-1:0] perf_lookups;
    logic [PERF_W-1:0] perf_hits;
    logic [PERF_W-1:0] perf_mispred;

    // pipeline side driving the predictor
    modport master (
        output if_pc, ex_valid, ex_pc, ex_inst, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target, inv_all,
        input  pred_hit, pred_taken, pred_target, flush, redirect_pc,
               perf_lookups, perf_hits, perf_mispred
    );

    // the predictor itself
    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_inst, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target, inv_all,
        output pred_hit, pred_taken, pred_target, flush, redirect_pc,
               perf_lookups, perf_hits, perf_mispred
    );
endinterface

// File: rtl/branch_target_predictor_lru_ages.sv
// True-LRU age tracker: one age per entry, ages always form a permutation of 0..ENTRIES-1.
module branch_target_predictor_lru_ages #(
    parameter int ENTRIES = 8,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             RST_n,
    input  logic             i_touch_en,
    input  logic [IDX_W-1:0] i_touch_idx,
    output logic [IDX_W-1:0] o_victim_idx
);

    logic [IDX_W-1:0] w_age [ENTRIES];
    logic [IDX_W-1:0] w_old_age;

    assign w_old_age = w_age[i_touch_idx];

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_age
        logic [IDX_W-1:0] r_age;
        assign w_age[gi] = r_age;

        // Touched entry becomes youngest; entries younger than its old age step back one
        always_ff @(posedge clk or negedge RST_n) begin
            if (!RST_n) begin
                r_age <= IDX_W'(gi);
            end else if (i_touch_en) begin
                if (i_touch_idx == IDX_W'(gi)) begin
                    r_age <= '0;
                end else if (r_age < w_old_age) begin
                    r_age <= r_age + IDX_W'(1);
                end
            end
        end
    end

    // Victim is the unique entry holding the maximum age
    always_comb begin
        o_victim_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_age[i] == IDX_W'(ENTRIES - 1)) begin
                o_victim_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Fully-associative BTB with saturating direction counters, true-LRU replacement,
// registered mispredict flush/redirect, saturating perf counters and bulk invalidate.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 8,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic                    clk,
    input  logic                    RST_n,
    branch_target_predictor_if.slave bus
);

    localparam int IDX_W = $clog2(ENTRIES);
    // Weakly-taken: MSB set, rest clear. Weakly-not-taken: MSB clear, rest set.
    localparam logic [CTR_W-1:0] W_CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] W_CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
        logic [CTR_W-1:0] ctr;
    } btb_entry_t;

    btb_entry_t         w_entry [ENTRIES];
    logic [ENTRIES-1:0] w_valid;
    logic [ENTRIES-1:0] w_lk_match;
    logic [ENTRIES-1:0] w_tr_match;

    logic [IDX_W-1:0]   w_lk_idx;
    logic [IDX_W-1:0]   w_tr_idx;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_lru_idx;
    logic [IDX_W-1:0]   w_alloc_idx;
    logic [IDX_W-1:0]   w_touch_idx;
    logic               w_lk_hit;
    logic               w_tr_hit;
    logic               w_has_free;

    logic [6:0]         w_opcode;
    logic               w_cf;
    logic               w_taken_eff;
    logic               w_mispred;
    logic               w_train;
    logic               w_touch_en;
    logic [XLEN-1:0]    w_actual_next;
    logic [XLEN-7-1:0]  w_unused_inst_bits;

    logic               r_flush;
    logic [XLEN-1:0]    r_redirect_pc;
    logic [PERF_W-1:0]  r_perf_lookups;
    logic [PERF_W-1:0]  r_perf_hits;
    logic [PERF_W-1:0]  r_perf_mispred;

    // ---------------- execute-side decode ----------------
    assign w_opcode           = bus.ex_inst[6:0];
    assign w_unused_inst_bits = bus.ex_inst[XLEN-1:7];
    assign w_cf               = bus.ex_valid && is_cf(w_opcode);
    assign w_taken_eff        = bus.ex_taken || is_jump(w_opcode);
    assign w_actual_next      = w_taken_eff ? bus.ex_target : (bus.ex_pc + XLEN'(4));
    assign w_mispred          = w_cf && ((w_taken_eff != bus.ex_pred_taken) ||
                                         (w_taken_eff && (bus.ex_target != bus.ex_pred_target)));
    // Bulk invalidate wins over training in the same cycle
    assign w_train            = w_cf && !bus.inv_all;

    // ---------------- entry storage and tag compare ----------------
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        btb_entry_t r_entry;

        assign w_entry[gi]    = r_entry;
        assign w_valid[gi]    = r_entry.valid;
        assign w_lk_match[gi] = r_entry.valid && (r_entry.tag == bus.if_pc);
        assign w_tr_match[gi] = r_entry.valid && (r_entry.tag == bus.ex_pc);

        // Per-entry update: invalidate, train on hit, or allocate on taken miss
        always_ff @(posedge clk or negedge RST_n) begin
            if (!RST_n) begin
                r_entry.valid  <= 1'b0;
                r_entry.tag    <= '0;
                r_entry.target <= '0;
                r_entry.ctr    <= W_CTR_WNT;
            end else if (bus.inv_all) begin
                r_entry.valid <= 1'b0;
            end else if (w_train && w_tr_hit && (w_tr_idx == IDX_W'(gi))) begin
                if (w_taken_eff) begin
                    if (r_entry.ctr != '1) begin
                        r_entry.ctr <= r_entry.ctr + CTR_W'(1);
                    end
                    r_entry.target <= bus.ex_target;
                end else if (r_entry.ctr != '0) begin
                    r_entry.ctr <= r_entry.ctr - CTR_W'(1);
                end
            end else if (w_train && !w_tr_hit && w_taken_eff && (w_alloc_idx == IDX_W'(gi))) begin
                r_entry.valid  <= 1'b1;
                r_entry.tag    <= bus.ex_pc;
                r_entry.target <= bus.ex_target;
                r_entry.ctr    <= W_CTR_WT;
            end
        end
    end

    // Encode the (at most one) matching entry for lookup and for training
    always_comb begin
        w_lk_idx = '0;
        w_tr_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_lk_match[i]) begin
                w_lk_idx = IDX_W'(i);
            end
            if (w_tr_match[i]) begin
                w_tr_idx = IDX_W'(i);
            end
        end
    end

    assign w_lk_hit = |w_lk_match;
    assign w_tr_hit = |w_tr_match;

    // Lowest-index invalid entry is preferred over evicting the LRU entry
    always_comb begin
        w_free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_has_free  = ~&w_valid;
    assign w_alloc_idx = w_has_free ? w_free_idx : w_lru_idx;

    // Recency only moves on a hit train or on an allocation
    assign w_touch_en  = w_train && (w_tr_hit || w_taken_eff);
    assign w_touch_idx = w_tr_hit ? w_tr_idx : w_alloc_idx;

    branch_target_predictor_lru_ages #(
        .ENTRIES (ENTRIES)
    ) u_lru (
        .clk          (clk),
        .RST_n        (RST_n),
        .i_touch_en   (w_touch_en),
        .i_touch_idx  (w_touch_idx),
        .o_victim_idx (w_lru_idx)
    );

    // ---------------- fetch-side lookup (pre-edge state, no bypass) ----------------
    assign bus.pred_hit    = w_lk_hit;
    assign bus.pred_taken  = w_lk_hit && w_entry[w_lk_idx].ctr[CTR_W-1];
    assign bus.pred_target = w_lk_hit ? w_entry[w_lk_idx].target : (bus.if_pc + XLEN'(4));

    // Flush is a one-cycle pulse; redirect follows every resolved control-flow op
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_flush <= w_mispred;
            if (w_cf) begin
                r_redirect_pc <= w_actual_next;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_perf_lookups <= '0;
            r_perf_hits    <= '0;
            r_perf_mispred <= '0;
        end else begin
            if (r_perf_lookups != '1) begin
                r_perf_lookups <= r_perf_lookups + PERF_W'(1);
            end
            if (w_lk_hit && (r_perf_hits != '1)) begin
                r_perf_hits <= r_perf_hits + PERF_W'(1);
            end
            if (w_mispred && (r_perf_mispred != '1)) begin
                r_perf_mispred <= r_perf_mispred + PERF_W'(1);
            end
        end
    end

    assign bus.flush        = r_flush;
    assign bus.redirect_pc  = r_redirect_pc;
    assign bus.perf_lookups = r_perf_lookups;
    assign bus.perf_hits    = r_perf_hits;
    assign bus.perf_mispred = r_perf_mispred;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed, table-driven bench for the branch target predictor.
module tb_branch_target_predictor;

    localparam logic [31:0] I_BEQ  = 32'h0000_0063;
    localparam logic [31:0] I_BNE  = 32'h0000_1063;
    localparam logic [31:0] I_JAL  = 32'h0000_006F;
    localparam logic [31:0] I_JALR = 32'h0000_0067;
    localparam logic [31:0] I_ADDI = 32'h0000_0013;

    logic clk;
    logic RST_n;

    branch_target_predictor_if #(.XLEN(32), .PERF_W(32)) bus ();

    branch_target_predictor #(
        .XLEN    (32),
        .ENTRIES (8),
        .CTR_W   (2),
        .PERF_W  (32)
    ) u_dut (
        .clk   (clk),
        .RST_n (RST_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ex_valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [31:0] target;
        logic        ptaken;
        logic [31:0] ptarget;
        logic        inv;
        logic [31:0] lpc;
        logic        e_flush;
        logic [31:0] e_redir;
        logic        e_hit;
        logic        e_taken;
        logic [31:0] e_target;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_mispred = 0;

    function automatic void add(logic v, logic [31:0] pc, logic [31:0] inst, logic tk,
                                logic [31:0] tg, logic pt, logic [31:0] ptg, logic inv,
                                logic [31:0] lpc, logic ef, logic [31:0] er,
                                logic eh, logic et, logic [31:0] etg);
        vec_t x;
        x.ex_valid = v;   x.pc = pc;     x.inst = inst;  x.taken = tk;
        x.target = tg;    x.ptaken = pt; x.ptarget = ptg; x.inv = inv;
        x.lpc = lpc;      x.e_flush = ef; x.e_redir = er;
        x.e_hit = eh;     x.e_taken = et; x.e_target = etg;
        vecs.push_back(x);
    endfunction

    function automatic void idle(logic [31:0] lpc, logic eh, logic et, logic [31:0] etg);
        add(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, lpc, 1'b0, 32'h0, eh, et, etg);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_ex();
        bus.ex_valid       = 1'b0;
        bus.ex_pc          = '0;
        bus.ex_inst        = '0;
        bus.ex_taken       = 1'b0;
        bus.ex_target      = '0;
        bus.ex_pred_taken  = 1'b0;
        bus.ex_pred_target = '0;
        bus.inv_all        = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int k);
        @(negedge clk);
        bus.ex_valid       = v.ex_valid;
        bus.ex_pc          = v.pc;
        bus.ex_inst        = v.inst;
        bus.ex_taken       = v.taken;
        bus.ex_target      = v.target;
        bus.ex_pred_taken  = v.ptaken;
        bus.ex_pred_target = v.ptarget;
        bus.inv_all        = v.inv;
        bus.if_pc          = v.lpc;
        @(posedge clk);
        #1;
        clear_ex();
        $display("vec %0d: ex_valid=%0b pc=%h inst=%h inv=%0b lookup=%h -> flush=%0b redir=%h hit=%0b taken=%0b target=%h",
                 k, v.ex_valid, v.pc, v.inst, v.inv, v.lpc, bus.flush, bus.redirect_pc,
                 bus.pred_hit, bus.pred_taken, bus.pred_target);
        chk($sformatf("v%0d flush", k), {31'b0, bus.flush}, {31'b0, v.e_flush});
        if (v.e_flush) chk($sformatf("v%0d redirect", k), bus.redirect_pc, v.e_redir);
        chk($sformatf("v%0d hit", k), {31'b0, bus.pred_hit}, {31'b0, v.e_hit});
        chk($sformatf("v%0d taken", k), {31'b0, bus.pred_taken}, {31'b0, v.e_taken});
        chk($sformatf("v%0d target", k), bus.pred_target, v.e_target);
    endtask

    // Watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_ex();
        bus.if_pc = 32'h100;
        RST_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst hit", {31'b0, bus.pred_hit}, 32'h0);
        chk("rst target", bus.pred_target, 32'h104);
        chk("rst flush", {31'b0, bus.flush}, 32'h0);
        chk("rst redirect", bus.redirect_pc, 32'h0);
        chk("rst perf_lookups", bus.perf_lookups, 32'h0);
        chk("rst perf_hits", bus.perf_hits, 32'h0);
        chk("rst perf_mispred", bus.perf_mispred, 32'h0);
        $display("reset: hit=%0b target=%h flush=%0b", bus.pred_hit, bus.pred_target, bus.flush);
        @(negedge clk);
        RST_n = 1'b1;

        // BEQ at 0x100 taken to 0x80 from a miss: flush, allocate weakly taken
        add(1, 32'h100, I_BEQ, 1, 32'h80, 0, 32'h104, 0, 32'h100, 1, 32'h80, 1, 1, 32'h80);
        // Not taken while predicted taken: flush to pc+4, ctr 10->01
        add(1, 32'h100, I_BEQ, 0, 32'h80, 1, 32'h80, 0, 32'h100, 1, 32'h104, 1, 0, 32'h80);
        // Not taken again, predicted correctly: ctr 01->00
        add(1, 32'h100, I_BEQ, 0, 32'h80, 0, 32'h104, 0, 32'h100, 0, 32'h0, 1, 0, 32'h80);
        idle(32'h100, 1, 0, 32'h80);
        // Saturate at 00
        add(1, 32'h100, I_BEQ, 0, 32'h80, 0, 32'h104, 0, 32'h100, 0, 32'h0, 1, 0, 32'h80);
        // Taken: 00->01 (still not taken)
        add(1, 32'h100, I_BEQ, 1, 32'h80, 0, 32'h104, 0, 32'h100, 1, 32'h80, 1, 0, 32'h80);
        // Taken: 01->10
        add(1, 32'h100, I_BEQ, 1, 32'h80, 0, 32'h104, 0, 32'h100, 1, 32'h80, 1, 1, 32'h80);
        // Taken, correct: 10->11, then saturate at 11
        add(1, 32'h100, I_BEQ, 1, 32'h80, 1, 32'h80, 0, 32'h100, 0, 32'h0, 1, 1, 32'h80);
        add(1, 32'h100, I_BEQ, 1, 32'h80, 1, 32'h80, 0, 32'h100, 0, 32'h0, 1, 1, 32'h80);
        // Not taken: 11->10, still predicts taken
        add(1, 32'h100, I_BEQ, 0, 32'h80, 1, 32'h80, 0, 32'h100, 1, 32'h104, 1, 1, 32'h80);
        // Taken with a new target: target mismatch flush, target updated
        add(1, 32'h100, I_BEQ, 1, 32'h90, 1, 32'h80, 0, 32'h100, 1, 32'h90, 1, 1, 32'h90);
        // Not-taken BNE miss predicted correctly: no flush, no allocation
        add(1, 32'h200, I_BNE, 0, 32'h280, 0, 32'h204, 0, 32'h200, 0, 32'h0, 0, 0, 32'h204);
        // Bulk invalidate while idle
        add(0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h100, 0, 32'h0, 0, 0, 32'h104);
        // Fill all 8 entries with JALs at 0x0..0x1C
        for (int i = 0; i < 8; i++) begin
            add(1, 32'(i * 4), I_JAL, 0, 32'h1000 + 32'(i * 4), 0, 32'(i * 4 + 4), 0,
                32'(i * 4), 1, 32'h1000 + 32'(i * 4), 1, 1, 32'h1000 + 32'(i * 4));
        end
        // Retrain 0x0 so 0x4 becomes least recently used
        add(1, 32'h0, I_JAL, 0, 32'h1000, 1, 32'h1000, 0, 32'h0, 0, 32'h0, 1, 1, 32'h1000);
        // New JAL at 0x40 evicts 0x4
        add(1, 32'h40, I_JAL, 0, 32'h2000, 0, 32'h44, 0, 32'h40, 1, 32'h2000, 1, 1, 32'h2000);
        idle(32'h4, 0, 0, 32'h8);
        idle(32'h0, 1, 1, 32'h1000);
        idle(32'h8, 1, 1, 32'h1008);
        idle(32'h40, 1, 1, 32'h2000);
        // inv_all with a same-cycle JAL train: training dropped, flush still raised
        add(1, 32'h300, I_JAL, 0, 32'h3000, 0, 32'h304, 1, 32'h300, 1, 32'h3000, 0, 0, 32'h304);
        idle(32'h0, 0, 0, 32'h4);
        idle(32'h40, 0, 0, 32'h44);
        // JALR with ex_taken=0 is still taken
        add(1, 32'h500, I_JALR, 0, 32'h600, 0, 32'h504, 0, 32'h500, 1, 32'h600, 1, 1, 32'h600);
        // Non control-flow instruction: no effect
        add(1, 32'h700, I_ADDI, 1, 32'h7777, 0, 32'h704, 0, 32'h700, 0, 32'h0, 0, 0, 32'h704);
        // PC+4 wraps
        idle(32'hFFFF_FFFC, 0, 0, 32'h0);

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].e_flush) exp_mispred++;
            apply(vecs[k], k);
        end
        chk("perf_mispred after table", bus.perf_mispred, 32'(exp_mispred));

        // Same-cycle train of the lookup PC is not bypassed
        @(negedge clk);
        bus.if_pc          = 32'h800;
        bus.ex_valid       = 1'b1;
        bus.ex_pc          = 32'h800;
        bus.ex_inst        = I_JAL;
        bus.ex_target      = 32'h900;
        bus.ex_pred_taken  = 1'b0;
        bus.ex_pred_target = 32'h804;
        #1;
        chk("bypass pre hit", {31'b0, bus.pred_hit}, 32'h0);
        chk("bypass pre target", bus.pred_target, 32'h804);
        @(posedge clk);
        #1;
        clear_ex();
        $display("bypass: post-edge hit=%0b target=%h flush=%0b", bus.pred_hit, bus.pred_target, bus.flush);
        chk("bypass post hit", {31'b0, bus.pred_hit}, 32'h1);
        chk("bypass post target", bus.pred_target, 32'h900);
        chk("bypass post flush", {31'b0, bus.flush}, 32'h1);

        // Asynchronous reset mid-operation discards the pending flush
        RST_n = 1'b0;
        #1;
        $display("mid reset: flush=%0b hit=%0b mispred=%0d", bus.flush, bus.pred_hit, bus.perf_mispred);
        chk("midrst flush", {31'b0, bus.flush}, 32'h0);
        chk("midrst redirect", bus.redirect_pc, 32'h0);
        chk("midrst hit", {31'b0, bus.pred_hit}, 32'h0);
        chk("midrst perf_mispred", bus.perf_mispred, 32'h0);
        chk("midrst perf_lookups", bus.perf_lookups, 32'h0);

        // Perf counter sequence: 2 miss cycles, 1 allocating cycle, 3 hit cycles
        bus.if_pc = 32'h0;
        @(negedge clk);
        RST_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.ex_valid       = 1'b1;
        bus.ex_pc          = 32'h0;
        bus.ex_inst        = I_JAL;
        bus.ex_target      = 32'h40;
        bus.ex_pred_taken  = 1'b0;
        bus.ex_pred_target = 32'h4;
        @(posedge clk);
        #1;
        clear_ex();
        repeat (3) @(posedge clk);
        #1;
        $display("perf: lookups=%0d hits=%0d mispred=%0d", bus.perf_lookups, bus.perf_hits, bus.perf_mispred);
        chk("perf lookups", bus.perf_lookups, 32'd6);
        chk("perf hits", bus.perf_hits, 32'd3);
        chk("perf mispred", bus.perf_mispred, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
